calc_result_checker: RTL

Synthesizable, parametrised result checker for the calculator datapath: signed add/sub/mul/div with divide-by-zero saturation. It sits beside the calculator DUT in the testbench harness, or in an FPGA build. It computes a reference result for each accepted operation, delays it by the DUT latency and compares it with the DUT output. Mismatches are reported as a pulse, a sticky flag, saturating counters and a first-error capture.

---
 rtl/calc_result_checker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/calc_result_checker.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : calc_result_checker                                            |
// | Brief   : Reference model + latency-matched comparator for the signed     |
// |           add/sub/mul/div calculator; pulse, sticky, counters, capture.  |
// |           Define CALC_CHK_DIV0_SAT_EN to check saturated divide-by-zero. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module calc_result_checker #(
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 2*DATA_W,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        func_in,
  input  logic [DATA_W-1:0] A_in,
  input  logic [DATA_W-1:0] B_in,
  input  logic [OUT_W-1:0]  out,
  input  logic              clr,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  chk_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [1:0]        first_err_func,
  output logic [OUT_W-1:0]  first_err_exp
);

  localparam int              c_tail    = LATENCY - 1;
  localparam logic [OUT_W-1:0] c_one    = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] c_sat_pos = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] c_sat_neg = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic signed [OUT_W-1:0] w_a_ext;
  logic signed [OUT_W-1:0] w_b_ext;
  logic signed [OUT_W-1:0] w_b_div;
  logic signed [OUT_W-1:0] w_exp;
  logic                    w_b_zero;
  logic                    w_checkable;
  logic                    w_cmp;
  logic                    w_mis;

  logic             r_vld  [LATENCY];
  logic             r_chk  [LATENCY];
  logic [1:0]       r_func [LATENCY];
  logic [OUT_W-1:0] r_exp  [LATENCY];

  assign w_a_ext  = {{(OUT_W-DATA_W){A_in[DATA_W-1]}}, A_in};
  assign w_b_ext  = {{(OUT_W-DATA_W){B_in[DATA_W-1]}}, B_in};
  assign w_b_zero = (B_in == '0);
  // Keep the divider operand non-zero so the quotient is never X in simulation.
  assign w_b_div  = w_b_zero ? $signed(c_one) : w_b_ext;

  always_comb begin
    w_exp       = '0;
    w_checkable = 1'b1;
    case (func_in)
      2'b00: w_exp = w_a_ext + w_b_ext;
      2'b01: w_exp = w_a_ext - w_b_ext;
      2'b10: w_exp = w_a_ext * w_b_ext;
      2'b11: begin
        if (w_b_zero) begin
`ifdef CALC_CHK_DIV0_SAT_EN
          w_exp = A_in[DATA_W-1] ? $signed(c_sat_neg) : $signed(c_sat_pos);
`else
          w_checkable = 1'b0;
`endif
        end else begin
          w_exp = w_a_ext / w_b_div;
        end
      end
    endcase
  end

  // Expected-result delay line; free-running, never stalled or flushed by clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i]  <= 1'b0;
        r_chk[i]  <= 1'b0;
        r_func[i] <= '0;
        r_exp[i]  <= '0;
      end
    end else begin
      r_vld[0]  <= in_valid;
      r_chk[0]  <= w_checkable;
      r_func[0] <= func_in;
      r_exp[0]  <= w_exp;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_chk[i]  <= r_chk[i-1];
        r_func[i] <= r_func[i-1];
        r_exp[i]  <= r_exp[i-1];
      end
    end
  end

  assign w_cmp = r_vld[c_tail] & r_chk[c_tail];
  assign w_mis = w_cmp & (out != r_exp[c_tail]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse      <= 1'b0;
      err_sticky     <= 1'b0;
      chk_count      <= '0;
      err_count      <= '0;
      first_err_func <= '0;
      first_err_exp  <= '0;
    end else if (clr) begin
      err_pulse      <= 1'b0;
      err_sticky     <= 1'b0;
      chk_count      <= '0;
      err_count      <= '0;
      first_err_func <= '0;
      first_err_exp  <= '0;
    end else begin
      err_pulse <= w_mis;
      if (w_cmp && (chk_count != c_cnt_max)) begin
        chk_count <= chk_count + 1'b1;
      end
      if (w_mis) begin
        if (err_count != c_cnt_max) begin
          err_count <= err_count + 1'b1;
        end
        err_sticky <= 1'b1;
        if (!err_sticky) begin
          first_err_func <= r_func[c_tail];
          first_err_exp  <= r_exp[c_tail];
        end
      end
    end
  end

endmodule
`default_nettype wire
